// File: rtl/hwag_trigger_gen.sv
// Crank/cam trigger-wheel generator: VR tooth train with a missing-tooth gap,
// a two-revolution cam signal and a runtime prescaler with optional
// per-revolution ramp.
module hwag_trigger_gen #(
    parameter int unsigned TOOTH_NUM  = 60,
    parameter int unsigned GAP_NUM    = 2,
    parameter int unsigned TPT        = 64,
    parameter int unsigned PRESC_W    = 16,
    parameter int unsigned CAM_TOGGLE = 30,
    parameter int unsigned CAM_RISE   = 4,
    parameter int unsigned CAM_FALL   = 54
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic [PRESC_W-1:0]                     presc_top,
    input  logic                                   load,
    input  logic                                   ramp_en,
    input  logic [PRESC_W-1:0]                     ramp_step,
    input  logic [PRESC_W-1:0]                     presc_max,
    output logic                                   vr,
    output logic                                   cam,
    output logic                                   cam_phase,
    output logic [$clog2(TOOTH_NUM-GAP_NUM)-1:0]   tooth_idx,
    output logic                                   rev_strobe
);

    localparam int unsigned NT     = TOOTH_NUM - GAP_NUM;
    localparam int unsigned LAST   = NT - 1;
    localparam int unsigned IDX_W  = $clog2(NT);
    localparam int unsigned TICK_W = $clog2((GAP_NUM + 1) * TPT + 1);

    localparam logic [TICK_W-1:0] LEN_N = TICK_W'(TPT);
    localparam logic [TICK_W-1:0] LEN_G = TICK_W'((GAP_NUM + 1) * TPT);

    logic [PRESC_W-1:0] scnt_q, scnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vr_q, vr_d;
    logic               cam_q, cam_d;
    logic               ph_q, ph_d;
    logic               rs_q, rs_d;

    logic [TICK_W-1:0]         len_cur, len_nxt;
    logic                      tick_adv, tooth_end;
    logic signed [PRESC_W+1:0] ramp_sum;
    logic [PRESC_W-1:0]        ramp_val;

    // Next-state: prescaler, tick/tooth counters, vr/cam decoding and ramp.
    always_comb begin
        scnt_d  = scnt_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        vr_d    = vr_q;
        cam_d   = cam_q;
        ph_d    = ph_q;
        rs_d    = 1'b0;

        len_cur = (idx_q == IDX_W'(LAST)) ? LEN_G : LEN_N;
        // >= rather than == so a load that drops presc below scnt wraps next clock
        tick_adv  = en && (scnt_q >= presc_q);
        tooth_end = tick_adv && (tick_q == len_cur - 1'b1);

        ramp_sum = $signed({2'b00, presc_q}) +
                   $signed({{2{ramp_step[PRESC_W-1]}}, ramp_step});
        if (ramp_sum[PRESC_W+1])
            ramp_val = '0;
        else if (ramp_sum > $signed({2'b00, presc_max}))
            ramp_val = presc_max;
        else
            ramp_val = ramp_sum[PRESC_W-1:0];

        if (en) begin
            if (tick_adv) begin
                scnt_d = '0;
                if (tooth_end) begin
                    tick_d = '0;
                    idx_d  = (idx_q == IDX_W'(LAST)) ? '0 : idx_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
        end

        len_nxt = (idx_d == IDX_W'(LAST)) ? LEN_G : LEN_N;
        if (tick_adv)
            vr_d = (tick_d >= (len_nxt >> 1));

        if (tooth_end) begin
            if (idx_d == IDX_W'(CAM_TOGGLE))
                ph_d = ~ph_q;
            if (idx_d == IDX_W'(CAM_RISE) && ph_q)
                cam_d = 1'b1;
            if (idx_d == IDX_W'(CAM_FALL) && ph_q)
                cam_d = 1'b0;
            if (idx_d == '0) begin
                rs_d = 1'b1;
                if (ramp_en)
                    presc_d = ramp_val;
            end
        end

        if (load)
            presc_d = presc_top;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q  <= '0;
            presc_q <= '0;
            tick_q  <= '0;
            idx_q   <= '0;
            vr_q    <= 1'b0;
            cam_q   <= 1'b1;
            ph_q    <= 1'b0;
            rs_q    <= 1'b0;
        end else begin
            scnt_q  <= scnt_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            vr_q    <= vr_d;
            cam_q   <= cam_d;
            ph_q    <= ph_d;
            rs_q    <= rs_d;
        end
    end

    assign vr         = vr_q;
    assign cam        = cam_q;
    assign cam_phase  = ph_q;
    assign tooth_idx  = idx_q;
    assign rev_strobe = rs_q;

endmodule

// File: tb/tb_hwag_trigger_gen.sv
// Directed bench for hwag_trigger_gen with default parameters.
module tb_hwag_trigger_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] presc_top;
    logic        load;
    logic        ramp_en;
    logic [15:0] ramp_step;
    logic [15:0] presc_max;
    logic        vr;
    logic        cam;
    logic        cam_phase;
    logic [5:0]  tooth_idx;
    logic        rev_strobe;

    int errors = 0;
    int checks = 0;

    hwag_trigger_gen #(
        .TOOTH_NUM(60), .GAP_NUM(2), .TPT(64), .PRESC_W(16),
        .CAM_TOGGLE(30), .CAM_RISE(4), .CAM_FALL(54)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .presc_top(presc_top), .load(load),
        .ramp_en(ramp_en), .ramp_step(ramp_step), .presc_max(presc_max),
        .vr(vr), .cam(cam), .cam_phase(cam_phase), .tooth_idx(tooth_idx),
        .rev_strobe(rev_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idx(input int idx, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (int'(tooth_idx) != idx && n < limit);
        if (int'(tooth_idx) != idx) n = -1;
    endtask

    task automatic wait_vr(input logic val, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (vr !== val && n < limit);
        if (vr !== val) n = -1;
    endtask

    task automatic wait_rs(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (rev_strobe !== 1'b1 && n < limit);
        if (rev_strobe !== 1'b1) n = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; presc_top = '0;
        ramp_en = 1'b0; ramp_step = '0; presc_max = '0;
        step(2);
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; en = 1'b1; load = 1'b1; presc_top = 16'd5;
        ramp_en = 1'b0; ramp_step = '0; presc_max = '0;
        step(2);
        checks++; if (vr !== 1'b0) begin errors++; $display("FAIL reset_vr: got %0b expected 0", vr); end
        checks++; if (cam !== 1'b1) begin errors++; $display("FAIL reset_cam: got %0b expected 1", cam); end
        checks++; if (cam_phase !== 1'b0) begin errors++; $display("FAIL reset_phase: got %0b expected 0", cam_phase); end
        checks++; if (tooth_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", tooth_idx); end
        checks++; if (rev_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b expected 0", rev_strobe); end
        rst = 1'b0; load = 1'b0; en = 1'b1;
        wait_vr(1'b1, 200, n);
        checks++; if (n != 32) begin errors++; $display("FAIL reset_first_rise: got %0d expected 32", n); end
    endtask

    task automatic test_tooth();
        int n, rises;
        logic prev;
        do_reset();
        wait_vr(1'b1, 200, n);
        checks++; if (n != 32) begin errors++; $display("FAIL tooth_low: got %0d expected 32", n); end
        wait_vr(1'b0, 200, n);
        checks++; if (n != 32) begin errors++; $display("FAIL tooth_high: got %0d expected 32", n); end
        checks++; if (tooth_idx !== 6'd1) begin errors++; $display("FAIL tooth_idx1: got %0d expected 1", tooth_idx); end
        wait_idx(57, 4000, n);
        checks++; if (n != 3584) begin errors++; $display("FAIL to_gap: got %0d expected 3584", n); end
        wait_vr(1'b1, 300, n);
        checks++; if (n != 96) begin errors++; $display("FAIL gap_low: got %0d expected 96", n); end
        wait_idx(0, 300, n);
        checks++; if (n != 96) begin errors++; $display("FAIL gap_high: got %0d expected 96", n); end
        checks++; if (rev_strobe !== 1'b1) begin errors++; $display("FAIL strobe_on_entry: got %0b expected 1", rev_strobe); end
        step(1);
        checks++; if (rev_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %0b expected 0", rev_strobe); end
        n = 1; rises = 0; prev = vr;
        do begin
            step(1); n++;
            if (vr && !prev) rises++;
            prev = vr;
        end while (rev_strobe !== 1'b1 && n < 5000);
        checks++; if (n != 3840) begin errors++; $display("FAIL rev_period: got %0d expected 3840", n); end
        checks++; if (rises != 58) begin errors++; $display("FAIL rev_rises: got %0d expected 58", rises); end
    endtask

    task automatic test_cam();
        int n, t;
        do_reset();
        wait_idx(30, 4000, n);
        checks++; if (cam_phase !== 1'b1) begin errors++; $display("FAIL cam_toggle1: got %0b expected 1", cam_phase); end
        checks++; if (cam !== 1'b1) begin errors++; $display("FAIL cam_init_hold: got %0b expected 1", cam); end
        wait_idx(53, 4000, n);
        checks++; if (cam !== 1'b1) begin errors++; $display("FAIL cam_before_fall: got %0b expected 1", cam); end
        wait_idx(54, 4000, n);
        checks++; if (cam !== 1'b0) begin errors++; $display("FAIL cam_fall: got %0b expected 0", cam); end
        t = 0;
        wait_idx(3, 4000, n); t += n;
        checks++; if (cam !== 1'b0) begin errors++; $display("FAIL cam_before_rise: got %0b expected 0", cam); end
        wait_idx(4, 4000, n); t += n;
        checks++; if (cam !== 1'b1) begin errors++; $display("FAIL cam_rise: got %0b expected 1", cam); end
        wait_idx(30, 4000, n); t += n;
        checks++; if (cam_phase !== 1'b0) begin errors++; $display("FAIL cam_toggle2: got %0b expected 0", cam_phase); end
        wait_idx(54, 4000, n); t += n;
        checks++; if (cam !== 1'b1) begin errors++; $display("FAIL cam_hold54: got %0b expected 1", cam); end
        wait_idx(4, 4000, n); t += n;
        checks++; if (cam !== 1'b1) begin errors++; $display("FAIL cam_hold4: got %0b expected 1", cam); end
        wait_idx(30, 4000, n); t += n;
        checks++; if (cam_phase !== 1'b1) begin errors++; $display("FAIL cam_toggle3: got %0b expected 1", cam_phase); end
        wait_idx(54, 4000, n); t += n;
        checks++; if (cam !== 1'b0) begin errors++; $display("FAIL cam_fall2: got %0b expected 0", cam); end
        checks++; if (t != 7680) begin errors++; $display("FAIL cam_period: got %0d expected 7680", t); end
    endtask

    task automatic test_load();
        int n;
        do_reset();
        wait_idx(2, 300, n);
        step(10);
        load = 1'b1; presc_top = 16'd3;
        step(1);
        load = 1'b0; presc_top = '0;
        wait_idx(3, 1000, n);
        checks++; if (n != 212) begin errors++; $display("FAIL load_tooth_end: got %0d expected 212", n); end
        wait_vr(1'b1, 1000, n);
        checks++; if (n != 128) begin errors++; $display("FAIL load_half: got %0d expected 128", n); end
        wait_idx(4, 1000, n);
        checks++; if (n != 128) begin errors++; $display("FAIL load_tooth: got %0d expected 128", n); end
    endtask

    task automatic test_enable();
        int n, bad;
        logic svr, scam, sph;
        do_reset();
        wait_idx(1, 300, n);
        step(20);
        svr = vr; scam = cam; sph = cam_phase;
        en = 1'b0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tooth_idx !== 6'd1 || vr !== svr || cam !== scam ||
                cam_phase !== sph || rev_strobe !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_outputs: got %0d changed cycles expected 0", bad); end
        en = 1'b1;
        wait_vr(1'b1, 300, n);
        checks++; if (n != 12) begin errors++; $display("FAIL hold_resume_rise: got %0d expected 12", n); end
        wait_idx(2, 300, n);
        checks++; if (n != 32) begin errors++; $display("FAIL hold_resume_end: got %0d expected 32", n); end
        en = 1'b0; load = 1'b1; presc_top = 16'd1;
        step(1);
        load = 1'b0; presc_top = '0;
        step(5);
        checks++; if (tooth_idx !== 6'd2) begin errors++; $display("FAIL hold_load_idx: got %0d expected 2", tooth_idx); end
        en = 1'b1;
        wait_idx(3, 500, n);
        checks++; if (n != 128) begin errors++; $display("FAIL hold_load_tooth: got %0d expected 128", n); end
    endtask

    task automatic test_ramp();
        int n;
        do_reset();
        ramp_en = 1'b1; ramp_step = 16'd1; presc_max = 16'd2;
        wait_rs(12000, n);
        checks++; if (n != 3840) begin errors++; $display("FAIL ramp_rev1: got %0d expected 3840", n); end
        wait_rs(12000, n);
        checks++; if (n != 7680) begin errors++; $display("FAIL ramp_rev2: got %0d expected 7680", n); end
        wait_rs(12000, n);
        checks++; if (n != 11520) begin errors++; $display("FAIL ramp_rev3: got %0d expected 11520", n); end
        ramp_step = 16'hFFFF;
        wait_rs(12000, n);
        checks++; if (n != 11520) begin errors++; $display("FAIL ramp_clamp_hi: got %0d expected 11520", n); end
        wait_rs(12000, n);
        checks++; if (n != 7680) begin errors++; $display("FAIL ramp_down1: got %0d expected 7680", n); end
        wait_rs(12000, n);
        checks++; if (n != 3840) begin errors++; $display("FAIL ramp_down0: got %0d expected 3840", n); end
        wait_idx(1, 200, n);
        checks++; if (n != 64) begin errors++; $display("FAIL ramp_clamp_lo: got %0d expected 64", n); end
        ramp_en = 1'b0; ramp_step = '0;
    endtask

    task automatic test_mid_reset();
        int n;
        do_reset();
        wait_idx(56, 4000, n);
        checks++; if (n != 3584) begin errors++; $display("FAIL pre_rst_time: got %0d expected 3584", n); end
        checks++; if (cam !== 1'b0 || cam_phase !== 1'b1) begin errors++; $display("FAIL pre_rst_cam: got cam=%0b phase=%0b expected cam=0 phase=1", cam, cam_phase); end
        step(10);
        rst = 1'b1;
        step(1);
        checks++; if (vr !== 1'b0 || cam !== 1'b1 || cam_phase !== 1'b0 || tooth_idx !== 6'd0 || rev_strobe !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got vr=%0b cam=%0b phase=%0b idx=%0d rs=%0b expected 0 1 0 0 0",
                     vr, cam, cam_phase, tooth_idx, rev_strobe);
        end
        rst = 1'b0;
        wait_vr(1'b1, 200, n);
        checks++; if (n != 32) begin errors++; $display("FAIL mid_reset_rise: got %0d expected 32", n); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; presc_top = '0;
        ramp_en = 1'b0; ramp_step = '0; presc_max = '0;
        test_reset();
        test_tooth();
        test_cam();
        test_load();
        test_enable();
        test_ramp();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
